rle_pixel_decoder: RTL and testbench



---
 rtl/video_pkg.sv | 25 ++
 rtl/instr_fifo.sv | 62 ++++++
 rtl/rle_pixel_decoder.sv | 151 +++++++++++++++
 tb/tb_rle_pixel_decoder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the RLE video path: instruction field layout,
// opcodes and decoder state encoding.
package video_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned RGB_W   = 6;

  // Instruction field positions
  localparam int unsigned OP_MSB  = 19;
  localparam int unsigned OP_LSB  = 18;
  localparam int unsigned COL_MSB = 17;
  localparam int unsigned COL_LSB = 12;
  localparam int unsigned RUN_LSB = 0;

  // Opcodes; 2'b1x is reserved
  localparam logic [1:0] OP_RUN = 2'b00;
  localparam logic [1:0] OP_EOF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_EOF_WAIT = 2'd2
  } dec_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO with combinational head read. A push into a
// full FIFO is only accepted when a pop happens in the same cycle.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rle_pixel_decoder.sv
// Run-length pixel decoder: buffers instructions, expands runs on the pixel
// strobe and reports sticky error conditions.
module rle_pixel_decoder
  import video_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RUN_W      = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  input  logic               pixel_req,
  input  logic               frame_start,
  output logic               instr_ready,
  output logic [RGB_W-1:0]   pixel_rgb,
  output logic               run_active,
  output logic               underrun,
  output logic               overflow,
  output logic               bad_instr
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [INSTR_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty, fifo_pop;

  dec_state_e         state_q, state_d;
  logic [RGB_W-1:0]   colour_q, colour_d;
  logic [RUN_W-1:0]   remaining_q, remaining_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               underrun_q, underrun_d;
  logic               overflow_q, overflow_d;
  logic               bad_q, bad_d;
  logic               ready_en_q, ready_en_d;

  logic [1:0]         head_op;
  logic [RGB_W-1:0]   head_colour;
  logic [RUN_W-1:0]   head_run;

  assign head_op     = fifo_head[OP_MSB:OP_LSB];
  assign head_colour = fifo_head[COL_MSB:COL_LSB];
  assign head_run    = fifo_head[RUN_LSB +: RUN_W];

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (instr_valid),
    .pop   (fifo_pop),
    .wdata (instruction),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ready_en_q holds instr_ready low until the first clock after reset release
  assign instr_ready = ready_en_q && (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
  assign pixel_rgb   = rgb_q;
  assign run_active  = (state_q == ST_RUN);
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;
  assign bad_instr   = bad_q;

  // Next-state, pixel output and FIFO pop decision
  always_comb begin
    state_d     = state_q;
    colour_d    = colour_q;
    remaining_d = remaining_q;
    rgb_d       = rgb_q;
    underrun_d  = underrun_q;
    overflow_d  = overflow_q;
    bad_d       = bad_q;
    ready_en_d  = 1'b1;
    fifo_pop    = 1'b0;

    if (frame_start) begin
      underrun_d = 1'b0;
      bad_d      = 1'b0;
      state_d    = ST_IDLE;
      if (pixel_req) rgb_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else if (pixel_req) begin
            rgb_d      = '0;
            underrun_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (pixel_req) begin
            rgb_d = colour_q;
            if (remaining_q != '0)  remaining_d = remaining_q - RUN_W'(1);
            else if (!fifo_empty)   fifo_pop    = 1'b1;
            else                    state_d     = ST_IDLE;
          end
        end
        ST_EOF_WAIT: begin
          if (pixel_req) rgb_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase

      // Shared dispatch of the popped head, from IDLE or from the last pixel of a run
      if (fifo_pop) begin
        if (head_op == OP_RUN) begin
          colour_d    = head_colour;
          remaining_d = head_run;
          state_d     = ST_RUN;
        end else if (head_op == OP_EOF) begin
          state_d = ST_EOF_WAIT;
        end else begin
          bad_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end

    if (instr_valid && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  // Decoder state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      colour_q    <= '0;
      remaining_q <= '0;
      rgb_q       <= '0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      bad_q       <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      colour_q    <= colour_d;
      remaining_q <= remaining_d;
      rgb_q       <= rgb_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
      bad_q       <= bad_d;
      ready_en_q  <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_rle_pixel_decoder.sv
// Self-checking bench for rle_pixel_decoder; expected pixels go into a
// scoreboard queue as requests are issued and are popped as pixels emerge.
module tb_rle_pixel_decoder;
  import video_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [INSTR_W-1:0] instruction = '0;
  logic               instr_valid = 1'b0;
  logic               pixel_req = 1'b0;
  logic               frame_start = 1'b0;
  logic               instr_ready;
  logic [RGB_W-1:0]   pixel_rgb;
  logic               run_active;
  logic               underrun;
  logic               overflow;
  logic               bad_instr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [RGB_W-1:0] exp_q[$];

  rle_pixel_decoder #(
    .FIFO_DEPTH (4),
    .RUN_W      (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pixel_req   (pixel_req),
    .frame_start (frame_start),
    .instr_ready (instr_ready),
    .pixel_rgb   (pixel_rgb),
    .run_active  (run_active),
    .underrun    (underrun),
    .overflow    (overflow),
    .bad_instr   (bad_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [INSTR_W-1:0] mk(input logic [1:0] op, input logic [5:0] col,
                                            input logic [11:0] len_m1);
    return {op, col, len_m1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [INSTR_W-1:0] w);
    instruction = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (run_active === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({instr_ready, pixel_rgb, run_active, underrun, overflow, bad_instr} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b",
               {instr_ready, pixel_rgb, run_active, underrun, overflow, bad_instr}, 11'b0);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (instr_ready !== 1'b1 || run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b run_active=%b expected ready=1 run_active=0",
               instr_ready, run_active);
    end
  endtask

  task automatic test_single_run();
    bit ok;
    logic [RGB_W-1:0] e;
    push_word(mk(OP_RUN, 6'h30, 12'd2));
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_run_load: run_active=%b expected 1", run_active); end
    exp_q.push_back(6'h30); exp_q.push_back(6'h30); exp_q.push_back(6'h30); exp_q.push_back(6'h00);
    pixel_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_rgb !== e) begin
        n_fail++;
        $display("FAIL single_run_px%0d: got %h expected %h", i, pixel_rgb, e);
      end
    end
    pixel_req = 1'b0;
    n_checks++;
    if (underrun !== 1'b1 || run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL single_run_underrun: underrun=%b run_active=%b expected 1 0", underrun, run_active);
    end
    pulse_frame();
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_clears_underrun: got %b expected 0", underrun);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [RGB_W-1:0] e;
    push_word(mk(OP_RUN, 6'h0C, 12'd0));
    push_word(mk(OP_RUN, 6'h03, 12'd1));
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_load: run_active=%b expected 1", run_active); end
    exp_q.push_back(6'h0C); exp_q.push_back(6'h03); exp_q.push_back(6'h03);
    pixel_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_rgb !== e) begin
        n_fail++;
        $display("FAIL b2b_px%0d: got %h expected %h", i, pixel_rgb, e);
      end
    end
    pixel_req = 1'b0;
    tick();
    n_checks++;
    if (pixel_rgb !== 6'h03 || underrun !== 1'b0 || run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold: rgb=%h underrun=%b run_active=%b expected 03 0 0",
               pixel_rgb, underrun, run_active);
    end
  endtask

  task automatic test_overflow();
    logic [RGB_W-1:0] e;
    logic [RGB_W-1:0] cols [4];
    logic             exp_rdy [4];
    bit ok;
    cols[0] = 6'h01; cols[1] = 6'h02; cols[2] = 6'h04; cols[3] = 6'h08;
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b0;
    // Park the decoder in EOF_WAIT so nothing is popped
    push_word(mk(OP_EOF, 6'h00, 12'd0));
    tick();
    for (int i = 0; i < 4; i++) begin
      push_word(mk(OP_RUN, cols[i], 12'd0));
      n_checks++;
      if (instr_ready !== exp_rdy[i]) begin
        n_fail++;
        $display("FAIL ovf_ready_after_push%0d: got %b expected %b", i + 1, instr_ready, exp_rdy[i]);
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_not_yet: got %b expected 0", overflow);
    end
    push_word(mk(OP_RUN, 6'h3F, 12'd0));
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    pulse_frame();
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ovf_drain_load: run_active=%b expected 1", run_active); end
    for (int i = 0; i < 4; i++) exp_q.push_back(cols[i]);
    exp_q.push_back(6'h00);
    pixel_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_rgb !== e) begin
        n_fail++;
        $display("FAIL ovf_drain_px%0d: got %h expected %h", i, pixel_rgb, e);
      end
    end
    pixel_req = 1'b0;
    pulse_frame();
    n_checks++;
    if (overflow !== 1'b1 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_sticky: overflow=%b underrun=%b expected 1 0", overflow, underrun);
    end
  endtask

  task automatic test_eof();
    bit ok;
    logic [RGB_W-1:0] e;
    push_word(mk(OP_RUN, 6'h3F, 12'd0));
    push_word(mk(OP_EOF, 6'h00, 12'd0));
    push_word(mk(OP_RUN, 6'h01, 12'd0));
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL eof_load: run_active=%b expected 1", run_active); end
    exp_q.push_back(6'h3F); exp_q.push_back(6'h00); exp_q.push_back(6'h00);
    pixel_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_rgb !== e) begin
        n_fail++;
        $display("FAIL eof_px%0d: got %h expected %h", i, pixel_rgb, e);
      end
    end
    pixel_req = 1'b0;
    n_checks++;
    if (underrun !== 1'b0 || run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL eof_wait_flags: underrun=%b run_active=%b expected 0 0", underrun, run_active);
    end
    pulse_frame();
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL eof_resume_load: run_active=%b expected 1", run_active); end
    exp_q.push_back(6'h01);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (pixel_rgb !== e) begin
      n_fail++;
      $display("FAIL eof_resume_px: got %h expected %h", pixel_rgb, e);
    end
  endtask

  task automatic test_bad_instr();
    bit ok;
    logic [RGB_W-1:0] e;
    push_word(mk(2'b11, 6'h15, 12'd5));
    tick();
    tick();
    n_checks++;
    if (bad_instr !== 1'b1 || run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_set: bad_instr=%b run_active=%b expected 1 0", bad_instr, run_active);
    end
    pulse_frame();
    n_checks++;
    if (bad_instr !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_clear: got %b expected 0", bad_instr);
    end
    push_word(mk(OP_RUN, 6'h2A, 12'd0));
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bad_next_load: run_active=%b expected 1", run_active); end
    exp_q.push_back(6'h2A);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (pixel_rgb !== e) begin
      n_fail++;
      $display("FAIL bad_next_px: got %h expected %h", pixel_rgb, e);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    logic [RGB_W-1:0] e;
    push_word(mk(OP_RUN, 6'h15, 12'd100));
    push_word(mk(OP_RUN, 6'h22, 12'd0));
    wait_run(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_mid_load: run_active=%b expected 1", run_active); end
    exp_q.push_back(6'h15); exp_q.push_back(6'h15);
    pixel_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (pixel_rgb !== e) begin
        n_fail++;
        $display("FAIL rst_mid_px%0d: got %h expected %h", i, pixel_rgb, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({instr_ready, pixel_rgb, run_active, underrun, overflow, bad_instr} !== 11'b0) begin
      n_fail++;
      $display("FAIL rst_async_outputs: got %b expected %b",
               {instr_ready, pixel_rgb, run_active, underrun, overflow, bad_instr}, 11'b0);
    end
    pixel_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (instr_ready !== 1'b1 || run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: ready=%b run_active=%b expected 1 0", instr_ready, run_active);
    end
    // FIFO contents were lost, so a request now underruns in IDLE
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    n_checks++;
    if (pixel_rgb !== 6'h00 || underrun !== 1'b1 || run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_fifo_lost: rgb=%h underrun=%b run_active=%b expected 00 1 0",
               pixel_rgb, underrun, run_active);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_overflow();
    test_eof();
    test_bad_instr();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
